apb_matmul_ctrl: RTL and testbench



---
 rtl/apb_matmul_ctrl_if.sv | 29 ++
 rtl/apb_matmul_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_apb_matmul_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_matmul_ctrl_if.sv
// APB bus bundle for apb_matmul_ctrl.
// The master drives the request side (select, enable, direction, strobes,
// write data, address); the slave returns read data, ready and error.
// Signal names keep the block's _i/_o suffixes as seen from the slave.
interface apb_matmul_ctrl_if #(
    parameter int BW     = 32,
    parameter int ADDR_W = 16,
    parameter int STRB_W = 4
);
    logic              psel_i;
    logic              penable_i;
    logic              pwrite_i;
    logic [STRB_W-1:0] pstrb_i;
    logic [BW-1:0]     pwdata_i;
    logic [ADDR_W-1:0] paddr_i;
    logic [BW-1:0]     prdata_o;
    logic              pready_o;
    logic              pslverr_o;

    modport master (
        output psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
        input  prdata_o, pready_o, pslverr_o
    );

    modport slave (
        input  psel_i, penable_i, pwrite_i, pstrb_i, pwdata_i, paddr_i,
        output prdata_o, pready_o, pslverr_o
    );
endinterface

// File: rtl/apb_matmul_ctrl.sv
// APB register file and sequencer for the systolic-array matrix multiplier.
// Holds operand A/B rows, an SPN-matrix scratchpad, CTRL/FLAGS/STATUS, and
// drains a finished result into a chosen scratchpad matrix one element/cycle.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   apb                 zero-wait APB slave (see apb_matmul_ctrl_if)
//   done_i/result_i/of_i  array completion, result matrix, overflow flags
//   operand_A_o/B_o     A/B rows, row r at [r*BW +: BW]
//   operand_C_o         bias matrix (scratchpad matrix CTRL[5:4] when CTRL[1])
//   control_reg_o       CTRL register
//   busy_o, irq_o       operation in progress, completion interrupt
module apb_matmul_ctrl #(
    parameter int DW      = 8,
    parameter int BW      = 32,
    parameter int ADDR_W  = 16,
    parameter int MAX_DIM = BW / DW,
    parameter int SPN     = 4,
    parameter int ELEMS   = MAX_DIM * MAX_DIM
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    apb_matmul_ctrl_if.slave       apb,
    input  logic                   done_i,
    input  logic [BW*ELEMS-1:0]    result_i,
    input  logic [ELEMS-1:0]       of_i,
    output logic [BW*MAX_DIM-1:0]  operand_A_o,
    output logic [BW*MAX_DIM-1:0]  operand_B_o,
    output logic [BW*ELEMS-1:0]    operand_C_o,
    output logic [15:0]            control_reg_o,
    output logic                   busy_o,
    output logic                   irq_o
);
    localparam int IDX_W    = ADDR_W - 5;
    localparam int ROW_W    = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int SP_DEPTH = SPN * ELEMS;
    localparam int SPA_W    = (SP_DEPTH > 1) ? $clog2(SP_DEPTH) : 1;
    localparam int CNT_W    = (ELEMS > 1) ? $clog2(ELEMS) : 1;

    localparam logic [4:0] OFF_CTRL   = 5'h00;
    localparam logic [4:0] OFF_OPA    = 5'h04;
    localparam logic [4:0] OFF_OPB    = 5'h08;
    localparam logic [4:0] OFF_FLAGS  = 5'h0C;
    localparam logic [4:0] OFF_SP     = 5'h10;
    localparam logic [4:0] OFF_STATUS = 5'h14;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t               state_reg;
    logic [15:0]          ctrl_reg, ctrl_next;
    logic [BW-1:0]        a_reg [MAX_DIM];
    logic [BW-1:0]        b_reg [MAX_DIM];
    logic [BW-1:0]        sp_reg [SP_DEPTH];
    logic [ELEMS-1:0]     flags_reg;
    logic                 done_sticky_reg, done_sticky_next;
    logic                 busy_reg;
    logic                 irq_reg;
    logic [BW*ELEMS-1:0]  shift_reg;
    logic [CNT_W-1:0]     cnt_reg;

    // ---------------- APB decode ----------------
    logic             access;
    logic [4:0]       offset;
    logic [IDX_W-1:0] idx;
    logic             row_ok, sp_ok;
    logic [ROW_W-1:0] row_sel;
    logic [SPA_W-1:0] sp_sel;
    logic             dec_err;
    logic [BW-1:0]    rd_word;
    logic             wr_en;

    assign access  = apb.psel_i & apb.penable_i;
    assign offset  = apb.paddr_i[4:0];
    assign idx     = apb.paddr_i[ADDR_W-1:5];
    assign row_ok  = idx < IDX_W'(MAX_DIM);
    // Linear scratchpad address is matrix*ELEMS + element, i.e. the index itself.
    assign sp_ok   = idx < IDX_W'(SP_DEPTH);
    assign row_sel = idx[ROW_W-1:0];
    assign sp_sel  = idx[SPA_W-1:0];

    always_comb begin
        dec_err = 1'b0;
        rd_word = '0;
        case (offset)
            OFF_CTRL: begin
                dec_err = apb.pwrite_i & busy_reg;
                rd_word = BW'(ctrl_reg);
            end
            OFF_OPA: begin
                dec_err = ~row_ok | (apb.pwrite_i & busy_reg);
                if (row_ok) rd_word = a_reg[row_sel];
            end
            OFF_OPB: begin
                dec_err = ~row_ok | (apb.pwrite_i & busy_reg);
                if (row_ok) rd_word = b_reg[row_sel];
            end
            OFF_FLAGS: begin
                dec_err = apb.pwrite_i;
                rd_word = BW'(flags_reg);
            end
            OFF_SP: begin
                dec_err = ~sp_ok | (apb.pwrite_i & busy_reg);
                if (sp_ok) rd_word = sp_reg[sp_sel];
            end
            OFF_STATUS: rd_word = BW'({|flags_reg, done_sticky_reg, busy_reg});
            default:    dec_err = 1'b1;
        endcase
    end

    assign apb.pready_o  = access;
    assign apb.pslverr_o = access & dec_err;
    assign apb.prdata_o  = (access & ~dec_err) ? rd_word : '0;
    assign wr_en         = access & apb.pwrite_i & ~dec_err;

    // ---------------- sequencer ----------------
    logic             drain_last;
    logic [SPA_W-1:0] drain_addr;
    logic [SPA_W-1:0] bias_base;

    assign drain_last = (state_reg == ST_DRAIN) && (cnt_reg == CNT_W'(ELEMS - 1));
    assign drain_addr = SPA_W'((32'(ctrl_reg[3:2]) % SPN) * ELEMS) + SPA_W'(cnt_reg);
    assign bias_base  = SPA_W'((32'(ctrl_reg[5:4]) % SPN) * ELEMS);

    // CTRL and done_sticky next values are shared by their registers and the
    // interrupt, so irq_o tracks a W1C or a completion on the same edge.
    // The completion set comes last so it wins over a simultaneous W1C.
    always_comb begin
        ctrl_next        = ctrl_reg;
        done_sticky_next = done_sticky_reg;
        if (wr_en && offset == OFF_CTRL)
            ctrl_next = apb.pwdata_i[15:0];
        if (wr_en && offset == OFF_STATUS && apb.pwdata_i[1])
            done_sticky_next = 1'b0;
        if (drain_last) begin
            ctrl_next[0]     = 1'b0;
            done_sticky_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_reg       <= ST_IDLE;
            ctrl_reg        <= '0;
            flags_reg       <= '0;
            done_sticky_reg <= 1'b0;
            busy_reg        <= 1'b0;
            irq_reg         <= 1'b0;
            shift_reg       <= '0;
            cnt_reg         <= '0;
            for (int r = 0; r < MAX_DIM; r++) begin
                a_reg[r] <= '0;
                b_reg[r] <= '0;
            end
            for (int e = 0; e < SP_DEPTH; e++) sp_reg[e] <= '0;
        end else begin
            ctrl_reg        <= ctrl_next;
            done_sticky_reg <= done_sticky_next;
            irq_reg         <= done_sticky_next & ctrl_next[7];

            // Data writes only reach here while idle (busy writes are errors).
            if (wr_en) begin
                for (int l = 0; l < MAX_DIM; l++) begin
                    if (apb.pstrb_i[l]) begin
                        case (offset)
                            OFF_OPA: a_reg[row_sel][l*DW +: DW] <= apb.pwdata_i[l*DW +: DW];
                            OFF_OPB: b_reg[row_sel][l*DW +: DW] <= apb.pwdata_i[l*DW +: DW];
                            OFF_SP:  sp_reg[sp_sel][l*DW +: DW] <= apb.pwdata_i[l*DW +: DW];
                            default: ;
                        endcase
                    end
                end
            end

            case (state_reg)
                ST_IDLE: begin
                    if (wr_en && offset == OFF_CTRL && apb.pwdata_i[0]) begin
                        state_reg <= ST_RUN;
                        busy_reg  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (done_i) begin
                        shift_reg <= result_i;
                        flags_reg <= of_i;
                        cnt_reg   <= '0;
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    sp_reg[drain_addr] <= shift_reg[BW-1:0];
                    shift_reg          <= shift_reg >> BW;
                    cnt_reg            <= cnt_reg + 1'b1;
                    if (drain_last) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // ---------------- outputs ----------------
    genvar gi;
    generate
        for (gi = 0; gi < MAX_DIM; gi++) begin : g_ops
            assign operand_A_o[gi*BW +: BW] = a_reg[gi];
            assign operand_B_o[gi*BW +: BW] = b_reg[gi];
        end
        for (gi = 0; gi < ELEMS; gi++) begin : g_bias
            assign operand_C_o[gi*BW +: BW] = ctrl_reg[1] ? sp_reg[bias_base + SPA_W'(gi)] : '0;
        end
    endgenerate

    assign control_reg_o = ctrl_reg;
    assign busy_o        = busy_reg;
    assign irq_o         = irq_reg;
endmodule

// File: tb/tb_apb_matmul_ctrl.sv
// Self-checking bench for apb_matmul_ctrl: directed scenarios plus randomized
// APB traffic and operations compared against a register-level model.
module tb_apb_matmul_ctrl;
    localparam int DW = 8, BW = 32, ADDR_W = 16, MAX_DIM = 4, SPN = 4, ELEMS = 16;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    always #5 clk = ~clk;

    apb_matmul_ctrl_if #(.BW(BW), .ADDR_W(ADDR_W), .STRB_W(MAX_DIM)) bus ();

    logic                  done_i = 1'b0;
    logic [BW*ELEMS-1:0]   result_i = '0;
    logic [ELEMS-1:0]      of_i = '0;
    logic [BW*MAX_DIM-1:0] operand_A_o, operand_B_o;
    logic [BW*ELEMS-1:0]   operand_C_o;
    logic [15:0]           control_reg_o;
    logic                  busy_o, irq_o;

    apb_matmul_ctrl #(.DW(DW), .BW(BW), .ADDR_W(ADDR_W), .MAX_DIM(MAX_DIM), .SPN(SPN), .ELEMS(ELEMS)) dut (
        .clk_i(clk), .reset_i(reset_i), .apb(bus),
        .done_i(done_i), .result_i(result_i), .of_i(of_i),
        .operand_A_o(operand_A_o), .operand_B_o(operand_B_o), .operand_C_o(operand_C_o),
        .control_reg_o(control_reg_o), .busy_o(busy_o), .irq_o(irq_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    logic [15:0] m_ctrl;
    logic [31:0] m_a [MAX_DIM];
    logic [31:0] m_b [MAX_DIM];
    logic [31:0] m_sp [SPN*ELEMS];
    logic [15:0] m_flags;
    bit          m_done, m_busy;

    task automatic model_reset();
        m_ctrl = '0; m_flags = '0; m_done = 0; m_busy = 0;
        for (int i = 0; i < MAX_DIM; i++) begin m_a[i] = '0; m_b[i] = '0; end
        for (int i = 0; i < SPN*ELEMS; i++) m_sp[i] = '0;
    endtask

    function automatic bit m_err(bit w, logic [15:0] addr);
        int idx = int'(addr[15:5]);
        case (addr[4:0])
            5'h00:        return w && m_busy;
            5'h04, 5'h08: return (idx >= MAX_DIM) || (w && m_busy);
            5'h0C:        return w;
            5'h10:        return (idx >= SPN*ELEMS) || (w && m_busy);
            5'h14:        return 0;
            default:      return 1;
        endcase
    endfunction

    function automatic logic [31:0] m_status();
        return {29'd0, |m_flags, m_done, m_busy};
    endfunction

    function automatic logic [31:0] m_read(logic [15:0] addr);
        int idx = int'(addr[15:5]);
        case (addr[4:0])
            5'h00:   return {16'd0, m_ctrl};
            5'h04:   return m_a[idx];
            5'h08:   return m_b[idx];
            5'h0C:   return {16'd0, m_flags};
            5'h10:   return m_sp[idx];
            default: return m_status();
        endcase
    endfunction

    task automatic model_write(logic [15:0] addr, logic [31:0] data, logic [3:0] strb);
        int idx = int'(addr[15:5]);
        logic [31:0] msk = '0;
        for (int l = 0; l < 4; l++) if (strb[l]) msk[l*8 +: 8] = 8'hFF;
        case (addr[4:0])
            5'h00: m_ctrl = data[15:0];
            5'h04: m_a[idx] = (m_a[idx] & ~msk) | (data & msk);
            5'h08: m_b[idx] = (m_b[idx] & ~msk) | (data & msk);
            5'h10: m_sp[idx] = (m_sp[idx] & ~msk) | (data & msk);
            5'h14: if (data[1]) m_done = 0;
            default: ;
        endcase
    endtask

    function automatic logic [BW*MAX_DIM-1:0] m_opa();
        logic [BW*MAX_DIM-1:0] v;
        for (int r = 0; r < MAX_DIM; r++) v[r*BW +: BW] = m_a[r];
        return v;
    endfunction

    function automatic logic [BW*MAX_DIM-1:0] m_opb();
        logic [BW*MAX_DIM-1:0] v;
        for (int r = 0; r < MAX_DIM; r++) v[r*BW +: BW] = m_b[r];
        return v;
    endfunction

    function automatic logic [BW*ELEMS-1:0] m_opc();
        logic [BW*ELEMS-1:0] v = '0;
        int src = int'(m_ctrl[5:4]) % SPN;
        if (m_ctrl[1]) for (int k = 0; k < ELEMS; k++) v[k*BW +: BW] = m_sp[src*ELEMS + k];
        return v;
    endfunction

    function automatic logic [15:0] rand_addr();
        logic [4:0]  off;
        logic [10:0] idx;
        off = 5'($urandom_range(0, 7) * 4);
        if ($urandom_range(0, 7) == 0) off = 5'($urandom);
        idx = ($urandom_range(0, 2) == 0) ? 11'($urandom_range(0, 70)) : 11'($urandom_range(0, 5));
        return {idx, off};
    endfunction

    // ---------------- stimulus tasks ----------------
    // One APB transfer; returns access-phase outputs, ends 1 time unit after the commit edge.
    task automatic apb_xfer(input bit w, input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output logic [31:0] rd, output logic err,
                            output logic rdy);
        @(negedge clk);
        bus.psel_i = 1; bus.penable_i = 0; bus.pwrite_i = w;
        bus.paddr_i = addr; bus.pwdata_i = data; bus.pstrb_i = strb;
        @(negedge clk);
        bus.penable_i = 1;
        #1;
        rd = bus.prdata_o; err = bus.pslverr_o; rdy = bus.pready_o;
        @(posedge clk);
        #1;
        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0;
        $display("apb %s addr=%h wdata=%h strb=%b rdata=%h err=%0b", w ? "WR" : "RD", addr, data, strb, rd, err);
    endtask

    // Pulses done_i, waits (bounded) for busy to drop, then applies the completion to the model.
    task automatic finish_op(input logic [BW*ELEMS-1:0] res, input logic [15:0] of, output int edges);
        int tgt;
        @(negedge clk);
        done_i = 1; result_i = res; of_i = of;
        @(posedge clk);
        #1;
        done_i = 0;
        edges = 1;
        while (busy_o === 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        tgt = int'(m_ctrl[3:2]) % SPN;
        for (int k = 0; k < ELEMS; k++) m_sp[tgt*ELEMS + k] = res[k*BW +: BW];
        m_flags = of; m_ctrl[0] = 0; m_done = 1; m_busy = 0;
        $display("op done: target=%0d of=%h busy fell after %0d edges", tgt, of, edges);
    endtask

    logic [31:0] rd;
    logic        err, rdy;

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_i = 1;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 0;
        model_reset();
        n_checks++; if (busy_o !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", busy_o); end
        n_checks++; if (irq_o !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b exp 0", irq_o); end
        n_checks++; if (control_reg_o !== 16'h0) begin n_errors++; $display("FAIL reset_ctrl: got %h exp 0", control_reg_o); end
        n_checks++; if (operand_A_o !== m_opa() || operand_B_o !== m_opb()) begin n_errors++; $display("FAIL reset_opab: got %h %h exp 0", operand_A_o, operand_B_o); end
        n_checks++; if (bus.pready_o !== 1'b0 || bus.pslverr_o !== 1'b0 || bus.prdata_o !== 32'h0) begin
            n_errors++; $display("FAIL reset_idle_bus: got rdy=%b err=%b rdata=%h exp 0 0 0", bus.pready_o, bus.pslverr_o, bus.prdata_o); end
        apb_xfer(0, 16'h0014, 32'h0, 4'h0, rd, err, rdy);
        n_checks++; if (rd !== m_status() || err !== 1'b0) begin n_errors++; $display("FAIL reset_status: got %h err=%b exp %h err=0", rd, err, m_status()); end
    endtask

    task automatic test_strobe_writes();
        logic [15:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        bit          e;
        apb_xfer(1, 16'h0044, 32'hAABBCCDD, 4'b0101, rd, err, rdy);
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL opa_strobe_err: got %b exp 0", err); end
        model_write(16'h0044, 32'hAABBCCDD, 4'b0101);
        apb_xfer(0, 16'h0044, 32'h0, 4'h0, rd, err, rdy);
        n_checks++; if (rd !== 32'h00BB00DD) begin n_errors++; $display("FAIL opa_strobe_read: got %h exp 00bb00dd", rd); end
        n_checks++; if (operand_A_o[95:64] !== 32'h00BB00DD) begin n_errors++; $display("FAIL opa_strobe_port: got %h exp 00bb00dd", operand_A_o[95:64]); end
        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 2))
                0: addr = {11'($urandom_range(0, 5)), 5'h04};
                1: addr = {11'($urandom_range(0, 5)), 5'h08};
                default: addr = {11'($urandom_range(0, 70)), 5'h10};
            endcase
            data = $urandom; strb = 4'($urandom);
            e = m_err(1, addr);
            apb_xfer(1, addr, data, strb, rd, err, rdy);
            n_checks++; if (err !== e) begin n_errors++; $display("FAIL rand_wr_err addr=%h: got %b exp %b", addr, err, e); end
            if (!e) model_write(addr, data, strb);
            e = m_err(0, addr);
            apb_xfer(0, addr, 32'h0, 4'h0, rd, err, rdy);
            n_checks++; if (err !== e || rd !== (e ? 32'h0 : m_read(addr))) begin
                n_errors++; $display("FAIL rand_readback addr=%h: got %h err=%b exp %h err=%b", addr, rd, err, e ? 32'h0 : m_read(addr), e); end
        end
        n_checks++; if (operand_A_o !== m_opa() || operand_B_o !== m_opb()) begin
            n_errors++; $display("FAIL opab_ports: got %h %h exp %h %h", operand_A_o, operand_B_o, m_opa(), m_opb()); end
    endtask

    task automatic test_operation();
        logic [BW*ELEMS-1:0] res;
        int edges;
        apb_xfer(1, 16'h0000, 32'h0089, 4'hF, rd, err, rdy);
        m_ctrl = 16'h0089; m_busy = 1;
        n_checks++; if (err !== 1'b0 || busy_o !== 1'b1) begin n_errors++; $display("FAIL start: got err=%b busy=%b exp err=0 busy=1", err, busy_o); end
        apb_xfer(1, 16'h0008, 32'h12345678, 4'hF, rd, err, rdy);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL busy_wr_err: got %b exp 1", err); end
        apb_xfer(1, 16'h0000, 32'h0000, 4'hF, rd, err, rdy);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL busy_ctrl_err: got %b exp 1", err); end
        apb_xfer(0, 16'h0008, 32'h0, 4'h0, rd, err, rdy);
        n_checks++; if (rd !== m_b[0] || err !== 1'b0) begin n_errors++; $display("FAIL busy_opb_kept: got %h err=%b exp %h err=0", rd, err, m_b[0]); end
        apb_xfer(0, 16'h0014, 32'h0, 4'h0, rd, err, rdy);
        n_checks++; if (rd !== m_status() || err !== 1'b0) begin n_errors++; $display("FAIL busy_status: got %h err=%b exp %h err=0", rd, err, m_status()); end
        for (int k = 0; k < ELEMS; k++) res[k*BW +: BW] = 32'(k + 1);
        finish_op(res, 16'h0001, edges);
        n_checks++; if (edges != ELEMS + 1 || busy_o !== 1'b0) begin n_errors++; $display("FAIL busy_fall: got %0d edges busy=%b exp %0d busy=0", edges, busy_o, ELEMS + 1); end
        n_checks++; if (irq_o !== 1'b1 || control_reg_o !== 16'h0088) begin n_errors++; $display("FAIL completion: got irq=%b ctrl=%h exp irq=1 ctrl=0088", irq_o, control_reg_o); end
        for (int k = 0; k < ELEMS; k++) begin
            apb_xfer(0, {11'(32 + k), 5'h10}, 32'h0, 4'h0, rd, err, rdy);
            n_checks++; if (rd !== 32'(k + 1) || err !== 1'b0) begin n_errors++; $display("FAIL sp_result %0d: got %h err=%b exp %h", 32 + k, rd, err, k + 1); end
        end
        apb_xfer(0, 16'h000C, 32'h0, 4'h0, rd, err, rdy);
        n_checks++; if (rd !== 32'h1) begin n_errors++; $display("FAIL flags: got %h exp 1", rd); end
        apb_xfer(0, 16'h0014, 32'h0, 4'h0, rd, err, rdy);
        n_checks++; if (rd !== 32'h6) begin n_errors++; $display("FAIL status_done: got %h exp 6", rd); end
    endtask

    task automatic test_status_w1c();
        apb_xfer(1, 16'h0014, 32'h2, 4'hF, rd, err, rdy);
        model_write(16'h0014, 32'h2, 4'hF);
        n_checks++; if (err !== 1'b0 || irq_o !== (m_done & m_ctrl[7])) begin n_errors++; $display("FAIL w1c_irq: got err=%b irq=%b exp err=0 irq=0", err, irq_o); end
        apb_xfer(0, 16'h0014, 32'h0, 4'h0, rd, err, rdy);
        n_checks++; if (rd !== m_status()) begin n_errors++; $display("FAIL w1c_status: got %h exp %h", rd, m_status()); end
    endtask

    task automatic test_bias();
        apb_xfer(1, 16'h0000, 32'h0022, 4'hF, rd, err, rdy);
        model_write(16'h0000, 32'h0022, 4'hF);
        n_checks++; if (operand_C_o[31:0] !== 32'h1) begin n_errors++; $display("FAIL bias_elem0: got %h exp 1", operand_C_o[31:0]); end
        n_checks++; if (operand_C_o !== m_opc()) begin n_errors++; $display("FAIL bias_matrix: got %h exp %h", operand_C_o, m_opc()); end
    endtask

    task automatic test_random_ops();
        logic [BW*ELEMS-1:0] res;
        logic [15:0] ctrl, addr, of;
        int edges;
        bit e;
        for (int op = 0; op < 3; op++) begin
            ctrl = 16'($urandom) | 16'h0001;
            apb_xfer(1, 16'h0000, {16'h0, ctrl}, 4'hF, rd, err, rdy);
            m_ctrl = ctrl; m_busy = 1;
            n_checks++; if (err !== 1'b0 || busy_o !== 1'b1) begin n_errors++; $display("FAIL rand_start: got err=%b busy=%b exp 0 1", err, busy_o); end
            for (int i = 0; i < 4; i++) begin
                addr = rand_addr();
                e = m_err(0, addr);
                apb_xfer(0, addr, 32'h0, 4'h0, rd, err, rdy);
                n_checks++; if (err !== e || rd !== (e ? 32'h0 : m_read(addr))) begin
                    n_errors++; $display("FAIL run_read addr=%h: got %h err=%b exp %h err=%b", addr, rd, err, e ? 32'h0 : m_read(addr), e); end
            end
            for (int k = 0; k < ELEMS; k++) res[k*BW +: BW] = $urandom;
            of = 16'($urandom);
            finish_op(res, of, edges);
            n_checks++; if (edges != ELEMS + 1) begin n_errors++; $display("FAIL rand_busy_fall: got %0d exp %0d", edges, ELEMS + 1); end
            n_checks++; if (irq_o !== (m_done & m_ctrl[7]) || control_reg_o !== m_ctrl) begin
                n_errors++; $display("FAIL rand_completion: got irq=%b ctrl=%h exp irq=%b ctrl=%h", irq_o, control_reg_o, m_done & m_ctrl[7], m_ctrl); end
            n_checks++; if (operand_C_o !== m_opc()) begin n_errors++; $display("FAIL rand_opc: got %h exp %h", operand_C_o, m_opc()); end
            for (int s = 0; s < SPN*ELEMS; s++) begin
                apb_xfer(0, {11'(s), 5'h10}, 32'h0, 4'h0, rd, err, rdy);
                n_checks++; if (rd !== m_sp[s]) begin n_errors++; $display("FAIL rand_sp %0d: got %h exp %h", s, rd, m_sp[s]); end
            end
            apb_xfer(0, 16'h0014, 32'h0, 4'h0, rd, err, rdy);
            n_checks++; if (rd !== m_status()) begin n_errors++; $display("FAIL rand_status: got %h exp %h", rd, m_status()); end
        end
    endtask

    task automatic test_errors();
        logic [15:0] addr;
        logic [31:0] data;
        bit w, e;
        apb_xfer(0, 16'h0018, 32'h0, 4'h0, rd, err, rdy);
        n_checks++; if (err !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL unmapped: got err=%b rd=%h exp 1 0", err, rd); end
        apb_xfer(0, 16'h0084, 32'h0, 4'h0, rd, err, rdy);
        n_checks++; if (err !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL opa_range: got err=%b rd=%h exp 1 0", err, rd); end
        apb_xfer(0, 16'h0810, 32'h0, 4'h0, rd, err, rdy);
        n_checks++; if (err !== 1'b1 || rd !== 32'h0) begin n_errors++; $display("FAIL sp_range: got err=%b rd=%h exp 1 0", err, rd); end
        apb_xfer(1, 16'h000C, 32'hFFFF, 4'hF, rd, err, rdy);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL flags_write: got %b exp 1", err); end
        for (int i = 0; i < 30; i++) begin
            addr = rand_addr(); data = $urandom; w = 1'($urandom);
            if (addr[4:0] == 5'h00) data[0] = 1'b0;
            e = m_err(w, addr);
            apb_xfer(w, addr, data, 4'($urandom), rd, err, rdy);
            n_checks++; if (err !== e || rdy !== 1'b1 || (!w && rd !== (e ? 32'h0 : m_read(addr)))) begin
                n_errors++; $display("FAIL rand_access w=%0b addr=%h: got rd=%h err=%b rdy=%b exp rd=%h err=%b rdy=1", w, addr, rd, err, rdy, e ? 32'h0 : m_read(addr), e); end
            if (w && !e) model_write(addr, data, bus.pstrb_i);
        end
    endtask

    task automatic test_reset_mid_drain();
        logic [31:0] data;
        apb_xfer(1, 16'h0000, 32'h0005, 4'hF, rd, err, rdy);
        @(negedge clk);
        done_i = 1; for (int k = 0; k < ELEMS; k++) result_i[k*BW +: BW] = $urandom | 32'h1;
        of_i = 16'hFFFF;
        @(posedge clk);
        #1;
        done_i = 0;
        repeat (4) @(posedge clk);
        #1;
        reset_i = 1;
        @(posedge clk);
        #1;
        reset_i = 0;
        model_reset();
        n_checks++; if (busy_o !== 1'b0 || control_reg_o !== 16'h0 || irq_o !== 1'b0) begin
            n_errors++; $display("FAIL mid_reset: got busy=%b ctrl=%h irq=%b exp 0 0 0", busy_o, control_reg_o, irq_o); end
        for (int s = 0; s < SPN*ELEMS; s++) begin
            apb_xfer(0, {11'(s), 5'h10}, 32'h0, 4'h0, rd, err, rdy);
            n_checks++; if (rd !== m_sp[s]) begin n_errors++; $display("FAIL mid_reset_sp %0d: got %h exp 0", s, rd); end
        end
        apb_xfer(0, 16'h0014, 32'h0, 4'h0, rd, err, rdy);
        n_checks++; if (rd !== m_status()) begin n_errors++; $display("FAIL mid_reset_status: got %h exp %h", rd, m_status()); end
        data = $urandom;
        apb_xfer(1, 16'h0024, data, 4'hF, rd, err, rdy);
        model_write(16'h0024, data, 4'hF);
        apb_xfer(0, 16'h0024, 32'h0, 4'h0, rd, err, rdy);
        n_checks++; if (rd !== m_a[1] || err !== 1'b0) begin n_errors++; $display("FAIL post_reset_rw: got %h err=%b exp %h err=0", rd, err, m_a[1]); end
    endtask

    initial begin
        bus.psel_i = 0; bus.penable_i = 0; bus.pwrite_i = 0;
        bus.pstrb_i = '0; bus.pwdata_i = '0; bus.paddr_i = '0;
        model_reset();
        test_reset();
        test_strobe_writes();
        test_operation();
        test_status_w1c();
        test_bias();
        test_errors();
        test_random_ops();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
